// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and widths for the memory arbiter slice.
//   - state_e : arbiter FSM states
//   - owner_e : requester encodings (loader = 0, CPU = 1)
//   - sel_e   : memory select encodings (instruction = 0, data = 1)
//   - ADDR_W / DATA_W : shared memory bus widths
package mem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef enum logic {
        OWN_LD  = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;

    typedef enum logic {
        SEL_INSTR = 1'b0,
        SEL_DATA  = 1'b1
    } sel_e;

endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker
//   Combinational winner selection between the loader and the CPU.
//   On a tie the port that did NOT own the previous grant wins; a lone
//   request always wins. Holding i_last_owner at OWN_CPU turns this into
//   fixed loader priority.
// Ports:
//   i_ld_req     : loader request
//   i_cpu_req    : CPU request
//   i_last_owner : owner of the most recent grant
//   o_winner     : selected owner (only meaningful when a request is present)
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic   i_ld_req,
    input  logic   i_cpu_req,
    input  owner_e i_last_owner,
    output owner_e o_winner
);

    always_comb begin
        o_winner = OWN_LD;
        if (i_ld_req && i_cpu_req) begin
            o_winner = (i_last_owner == OWN_LD) ? OWN_CPU : OWN_LD;
        end else if (i_cpu_req) begin
            o_winner = OWN_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates a UART loader (instruction-memory writes only) and a CPU
//   (reads/writes to instruction or data memory) onto one shared memory bus.
//   One transaction at a time: IDLE -> ISSUE -> (RDWAIT) -> RESP -> IDLE.
//   Write done appears two cycles after the request is sampled, read done
//   (with o_cpu_rdata) three cycles after.
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN defined   : round-robin on simultaneous requests
//   MEM_ARB_ROUND_ROBIN_EN undefined : loader always wins, no pointer flop
// Ports:
//   i_clk, i_rst                     : clock, synchronous active-high reset
//   i_ld_req/addr/wdata, o_ld_done   : loader write port
//   i_cpu_req/we/sel/addr/wdata      : CPU command (sel 0=instr, 1=data)
//   o_cpu_rdata/done/err             : CPU response
//   o_mem_*_we/re, o_mem_addr/wdata  : registered memory strobes and bus
//   i_mem_instr_rdata/data_rdata     : memory read data, one cycle after re
//   o_busy, o_owner                  : FSM not idle, current owner
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ld_req,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_wdata,
    output logic              o_ld_done,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic              i_cpu_sel,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_done,
    output logic              o_cpu_err,
    output logic              o_mem_instr_we,
    output logic              o_mem_instr_re,
    output logic              o_mem_data_we,
    output logic              o_mem_data_re,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_instr_rdata,
    input  logic [DATA_W-1:0] i_mem_data_rdata,
    output logic              o_busy,
    output logic              o_owner
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    sel_e              sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              instr_we_q, instr_we_d;
    logic              instr_re_q, instr_re_d;
    logic              data_we_q, data_we_d;
    logic              data_re_q, data_re_d;
    logic              ld_done_q, ld_done_d;
    logic              cpu_done_q, cpu_done_d;
    logic              cpu_err_q, cpu_err_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    logic   any_req;
    owner_e winner;
    owner_e last_owner;

    assign any_req = i_ld_req | i_cpu_req;

    mem_arb_picker u_picker (
        .i_ld_req     (i_ld_req),
        .i_cpu_req    (i_cpu_req),
        .i_last_owner (last_owner),
        .o_winner     (winner)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e last_q, last_d;

    // Pointer moves only when a grant is actually taken.
    always_comb begin
        last_d = last_q;
        if ((state_q == IDLE) && any_req) begin
            last_d = winner;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q <= OWN_CPU;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_owner = last_q;
`else
    // A constant "CPU last" pointer makes the picker favour the loader.
    assign last_owner = OWN_CPU;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        instr_we_d  = 1'b0;
        instr_re_d  = 1'b0;
        data_we_d   = 1'b0;
        data_re_d   = 1'b0;
        ld_done_d   = 1'b0;
        cpu_done_d  = 1'b0;
        cpu_err_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = winner;
                    if (winner == OWN_LD) begin
                        we_d    = 1'b1;
                        sel_d   = SEL_INSTR;
                        addr_d  = i_ld_addr;
                        wdata_d = i_ld_wdata;
                    end else begin
                        we_d    = i_cpu_we;
                        sel_d   = sel_e'(i_cpu_sel);
                        addr_d  = i_cpu_addr;
                        wdata_d = i_cpu_wdata;
                    end
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (we_q) begin
                    // A CPU write to instruction memory is refused: no strobe,
                    // the error is reported with the done pulse in RESP.
                    if (sel_q == SEL_DATA) begin
                        data_we_d = 1'b1;
                    end else if (owner_q == OWN_LD) begin
                        instr_we_d = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    if (sel_q == SEL_DATA) begin
                        data_re_d = 1'b1;
                    end else begin
                        instr_re_d = 1'b1;
                    end
                    state_d = RDWAIT;
                end
            end

            // The re strobe is on the bus during this state; memory data
            // follows one cycle later, i.e. while in RESP.
            RDWAIT: begin
                state_d = RESP;
            end

            RESP: begin
                if (owner_q == OWN_LD) begin
                    ld_done_d = 1'b1;
                end else begin
                    cpu_done_d = 1'b1;
                    cpu_err_d  = we_q && (sel_q == SEL_INSTR);
                    if (!we_q) begin
                        cpu_rdata_d = (sel_q == SEL_DATA) ? i_mem_data_rdata
                                                          : i_mem_instr_rdata;
                    end
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_LD;
            we_q        <= 1'b0;
            sel_q       <= SEL_INSTR;
            addr_q      <= '0;
            wdata_q     <= '0;
            instr_we_q  <= 1'b0;
            instr_re_q  <= 1'b0;
            data_we_q   <= 1'b0;
            data_re_q   <= 1'b0;
            ld_done_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            instr_we_q  <= instr_we_d;
            instr_re_q  <= instr_re_d;
            data_we_q   <= data_we_d;
            data_re_q   <= data_re_d;
            ld_done_q   <= ld_done_d;
            cpu_done_q  <= cpu_done_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign o_mem_instr_we = instr_we_q;
    assign o_mem_instr_re = instr_re_q;
    assign o_mem_data_we  = data_we_q;
    assign o_mem_data_re  = data_re_q;
    assign o_mem_addr     = addr_q;
    assign o_mem_wdata    = wdata_q;
    assign o_ld_done      = ld_done_q;
    assign o_cpu_done     = cpu_done_q;
    assign o_cpu_err      = cpu_err_q;
    assign o_cpu_rdata    = cpu_rdata_q;
    assign o_busy         = (state_q != IDLE);
    assign o_owner        = owner_q;

endmodule
